// File: rtl/vgatext_pkg.sv
// Shared constants and helpers for the text-mode pixel engine.
package vgatext_pkg;

   localparam int unsigned CHAR_W  = 8;
   localparam int unsigned LATENCY = 3;

   // Bit positions inside a 16-bit text cell word.
   localparam int unsigned ATTR_CHAR_LSB = 0;
   localparam int unsigned ATTR_FG_LSB   = 8;
   localparam int unsigned ATTR_FG_INT   = 11;
   localparam int unsigned ATTR_BG_LSB   = 12;
   localparam int unsigned ATTR_BLINK    = 15;

   // Address width needed to index a text buffer of the given cell count.
   function automatic int unsigned addr_width(input int unsigned cells);
      return (cells > 1) ? $clog2(cells) : 1;
   endfunction

endpackage

// File: rtl/vga_font_rom.sv
// Synchronous-read glyph ROM, 256 characters by FONT_H scanlines of 8 pixels.
// Glyphs come from a built-in table so the ROM needs no external init file;
// 8-line fonts sample every other row of the 16-line table.
module vga_font_rom #(
   parameter int unsigned FONT_H = 16
) (
   input  logic       clk,
   input  logic [7:0] char_code,
   input  logic [3:0] line,
   output logic [7:0] glyph
);

   // NUL and space are blank, 'A' is a real glyph, everything else is a box outline.
   function automatic logic [7:0] glyph_row(input logic [7:0] c, input logic [3:0] r);
      logic [7:0] g;
      g = 8'h00;
      if (c == 8'h41) begin
         case (r)
            4'd2:                      g = 8'h10;
            4'd3:                      g = 8'h38;
            4'd4:                      g = 8'h6C;
            4'd7:                      g = 8'hFE;
            4'd5, 4'd6, 4'd8, 4'd9,
            4'd10, 4'd11:              g = 8'hC6;
            default:                   g = 8'h00;
         endcase
      end else if (c != 8'h00 && c != 8'h20) begin
         g = (r == 4'd0 || r == 4'd15) ? 8'hFF : 8'h81;
      end
      return g;
   endfunction

   logic [3:0] table_row;

   // Map the scanline onto the 16-row table.
   always_comb begin
      table_row = line;
      if (FONT_H == 8) table_row = {line[2:0], 1'b0};
   end

   // Registered read.
   always_ff @(posedge clk) begin
      glyph <= glyph_row(char_code, table_row);
   end

endmodule

// File: rtl/vga_text_engine.sv
// Text-mode pixel engine: text RAM -> font ROM -> colour, with blink, cursor and
// sync outputs delayed to match the 3-clock pixel pipeline.
module vga_text_engine
   import vgatext_pkg::*;
#(
   parameter int unsigned COLS          = 80,
   parameter int unsigned ROWS          = 30,
   parameter int unsigned FONT_H        = 16,
   parameter int unsigned BLINK_FRAMES  = 16,
   parameter int unsigned CURSOR_START  = 14,
   parameter int unsigned WR_BLANK_ONLY = 0,
   localparam int unsigned ADDR_W       = addr_width(COLS * ROWS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              video_on,
   input  logic              hsync_n_in,
   input  logic              vsync_n_in,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   input  logic              cursor_en,
   input  logic [6:0]        cursor_col,
   input  logic [5:0]        cursor_row,
   output logic [2:0]        color,
   output logic              intensity,
   output logic              hsync_n_out,
   output logic              vsync_n_out
);

   localparam int unsigned CELLS = COLS * ROWS;

   logic [6:0]        s0_col, s0_row;
   logic [3:0]        s0_line;
   logic [2:0]        s0_bit;
   logic              s0_in_range, s0_cursor;
   logic [ADDR_W-1:0] s0_addr;

   // Split the pixel position into cell coordinates and in-cell offsets.
   always_comb begin
      s0_col  = pixel_x[9:3];
      s0_bit  = pixel_x[2:0];
      s0_row  = {1'b0, pixel_y[9:4]};
      s0_line = pixel_y[3:0];
      if (FONT_H == 8) begin
         s0_row  = pixel_y[9:3];
         s0_line = {1'b0, pixel_y[2:0]};
      end
      s0_in_range = (32'(s0_col) < COLS) && (32'(s0_row) < ROWS);
      s0_addr     = ADDR_W'(32'(s0_row) * COLS + 32'(s0_col));
      s0_cursor   = cursor_en && (s0_col == cursor_col) && (s0_row == {1'b0, cursor_row});
   end

   logic [15:0] text_ram [CELLS];
   logic [15:0] s1_cell;
   logic        wr_en;

   assign wr_ready = (WR_BLANK_ONLY != 0) ? ~video_on : 1'b1;
   // Out-of-range writes are acknowledged but dropped.
   assign wr_en    = wr_valid && wr_ready && (32'(wr_addr) < CELLS);

   // Simple dual-port text RAM, read-first on an address collision; never reset.
   always_ff @(posedge clk) begin
      if (wr_en) text_ram[wr_addr] <= wr_data;
      s1_cell <= text_ram[s0_addr];
   end

   logic       s1_valid, s1_cursor;
   logic [3:0] s1_line;
   logic [2:0] s1_bit;
   logic       s2_valid, s2_cursor;
   logic [3:0] s2_line;
   logic [2:0] s2_bit;
   logic [15:8] s2_attr;
   logic [7:0] s2_glyph;

   // Side-band pipeline that travels alongside the RAM and ROM reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_cursor <= 1'b0;
         s1_line   <= '0;
         s1_bit    <= '0;
         s2_valid  <= 1'b0;
         s2_cursor <= 1'b0;
         s2_line   <= '0;
         s2_bit    <= '0;
         s2_attr   <= '0;
      end else begin
         s1_valid  <= video_on && s0_in_range;
         s1_cursor <= s0_cursor;
         s1_line   <= s0_line;
         s1_bit    <= s0_bit;
         s2_valid  <= s1_valid;
         s2_cursor <= s1_cursor;
         s2_line   <= s1_line;
         s2_bit    <= s1_bit;
         s2_attr   <= s1_cell[15:8];
      end
   end

   vga_font_rom #(
      .FONT_H(FONT_H)
   ) u_font (
      .clk      (clk),
      .char_code(s1_cell[ATTR_CHAR_LSB +: CHAR_W]),
      .line     (s1_line),
      .glyph    (s2_glyph)
   );

   logic       vs_prev, blink_phase;
   logic [7:0] blink_cnt;

   // Count vsync falling edges; toggle the blink phase every BLINK_FRAMES frames.
   always_ff @(posedge clk) begin
      if (reset) begin
         vs_prev     <= 1'b1;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         vs_prev <= vsync_n_in;
         if (vs_prev && !vsync_n_in) begin
            if (32'(blink_cnt) + 1 >= BLINK_FRAMES) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 8'd1;
            end
         end
      end
   end

   logic       pix_on, int_d;
   logic [2:0] color_d;

   // Glyph bit -> cursor inversion -> blink blanking -> fg/bg selection.
   always_comb begin
      pix_on = s2_glyph[3'd7 - s2_bit];
      if (s2_cursor && (32'(s2_line) >= CURSOR_START) && !blink_phase) pix_on = ~pix_on;
      if (s2_attr[ATTR_BLINK] && blink_phase) pix_on = 1'b0;
      color_d = pix_on ? s2_attr[ATTR_FG_LSB +: 3] : s2_attr[ATTR_BG_LSB +: 3];
      int_d   = pix_on & s2_attr[ATTR_FG_INT];
      if (!s2_valid) begin
         color_d = '0;
         int_d   = 1'b0;
      end
   end

   logic [LATENCY-1:0] hs_pipe, vs_pipe;

   // Output register and matching sync delay line.
   always_ff @(posedge clk) begin
      if (reset) begin
         color     <= '0;
         intensity <= 1'b0;
         hs_pipe   <= '1;
         vs_pipe   <= '1;
      end else begin
         color     <= color_d;
         intensity <= int_d;
         hs_pipe   <= {hs_pipe[LATENCY-2:0], hsync_n_in};
         vs_pipe   <= {vs_pipe[LATENCY-2:0], vsync_n_in};
      end
   end

   assign hsync_n_out = hs_pipe[LATENCY-1];
   assign vsync_n_out = vs_pipe[LATENCY-1];

endmodule

// File: tb/tb_vga_text_engine.sv
// Directed, table-driven bench for vga_text_engine.
module tb_vga_text_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  pixel_x, pixel_y;
   logic        video_on, hsync_n_in, vsync_n_in;
   logic        wr_valid, b_wr_valid;
   logic [11:0] wr_addr;
   logic [15:0] wr_data;
   logic        cursor_en;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;
   logic        wr_ready, b_wr_ready;
   logic [2:0]  color, b_color;
   logic        intensity, b_intensity;
   logic        hsync_n_out, vsync_n_out, b_hs, b_vs;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   vga_text_engine dut (
      .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
      .hsync_n_in(hsync_n_in), .vsync_n_in(vsync_n_in), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .cursor_en(cursor_en),
      .cursor_col(cursor_col), .cursor_row(cursor_row), .color(color),
      .intensity(intensity), .hsync_n_out(hsync_n_out), .vsync_n_out(vsync_n_out)
   );

   vga_text_engine #(.WR_BLANK_ONLY(1)) dut_b (
      .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
      .hsync_n_in(hsync_n_in), .vsync_n_in(vsync_n_in), .wr_valid(b_wr_valid),
      .wr_ready(b_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .cursor_en(cursor_en),
      .cursor_col(cursor_col), .cursor_row(cursor_row), .color(b_color),
      .intensity(b_intensity), .hsync_n_out(b_hs), .vsync_n_out(b_vs)
   );

   typedef struct {
      string name;
      int    x;
      int    y;
      bit    von;
      int    col;
      int    inten;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Hold one pixel for the full pipeline depth so the outputs belong to it.
   task automatic pix(input int x, input int y, input bit von);
      pixel_x  = x[9:0];
      pixel_y  = y[9:0];
      video_on = von;
      repeat (3) step();
   endtask

   task automatic wr(input int addr, input int data);
      video_on = 1'b0;
      wr_addr  = addr[11:0];
      wr_data  = data[15:0];
      wr_valid = 1'b1;
      #0;
      chk("wr_ready", int'(wr_ready), 1);
      step();
      wr_valid = 1'b0;
   endtask

   task automatic vs_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         vsync_n_in = 1'b0;
         step();
         vsync_n_in = 1'b1;
         step();
      end
   endtask

   vec_t vecs[$];
   logic [15:0] hp, vp;

   initial begin
      reset = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
      hsync_n_in = 1'b0; vsync_n_in = 1'b0; wr_valid = 1'b0; b_wr_valid = 1'b0;
      wr_addr = '0; wr_data = '0; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;

      // Reset state
      repeat (3) step();
      chk("reset color", int'(color), 0);
      chk("reset intensity", int'(intensity), 0);
      chk("reset hsync_out", int'(hsync_n_out), 1);
      chk("reset vsync_out", int'(vsync_n_out), 1);

      hsync_n_in = 1'b1; vsync_n_in = 1'b1;
      reset = 1'b0;
      step();

      // Clear both text RAMs during blanking.
      wr_valid = 1'b1; b_wr_valid = 1'b1; wr_data = '0;
      for (int a = 0; a < 2400; a++) begin
         wr_addr = a[11:0];
         step();
      end
      wr_valid = 1'b0; b_wr_valid = 1'b0;

      // Sync delay of exactly 3 clocks, black everywhere over an empty RAM.
      hp = 16'b1100_1010_0111_0001;
      vp = 16'b1011_0011_1000_1101;
      video_on = 1'b1;
      for (int k = 0; k < 16; k++) begin
         hsync_n_in = hp[k];
         vsync_n_in = vp[k];
         pixel_x    = 10'(k * 37);
         pixel_y    = 10'(k * 29);
         step();
         if (k >= 2) begin
            chk("hsync delay", int'(hsync_n_out), int'(hp[k-2]));
            chk("vsync delay", int'(vsync_n_out), int'(vp[k-2]));
            chk("empty color", int'(color), 0);
            chk("empty intensity", int'(intensity), 0);
         end
      end
      hsync_n_in = 1'b1; vsync_n_in = 1'b1;

      // Reset again to clear the blink counter; the RAM keeps its contents.
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();

      wr(0, 16'h0F41);
      wr(1, 16'h8F41);
      wr(80, 16'h9E20);
      wr(165, 16'h0E00);
      wr(2400, 16'h1000);

      vecs.push_back('{"A row0", 0, 0, 1'b1, 0, 0});
      vecs.push_back('{"A row2 x3", 3, 2, 1'b1, 7, 1});
      vecs.push_back('{"A row5 x0", 0, 5, 1'b1, 7, 1});
      vecs.push_back('{"A row5 x2", 2, 5, 1'b1, 0, 0});
      vecs.push_back('{"A row7 x7", 7, 7, 1'b1, 0, 0});
      vecs.push_back('{"A row7 x6", 6, 7, 1'b1, 7, 1});
      vecs.push_back('{"A row15", 0, 15, 1'b1, 0, 0});
      vecs.push_back('{"video off", 0, 5, 1'b0, 0, 0});
      vecs.push_back('{"blank cell2", 16, 5, 1'b1, 0, 0});
      vecs.push_back('{"bg cell80", 3, 16, 1'b1, 1, 0});
      vecs.push_back('{"x640 black", 640, 0, 1'b1, 0, 0});
      vecs.push_back('{"y480 black", 0, 480, 1'b1, 0, 0});
      vecs.push_back('{"blink A on", 8, 5, 1'b1, 7, 1});
      foreach (vecs[i]) begin
         pix(vecs[i].x, vecs[i].y, vecs[i].von);
         chk({vecs[i].name, " color"}, int'(color), vecs[i].col);
         chk({vecs[i].name, " intensity"}, int'(intensity), vecs[i].inten);
      end

      // Blink: 15 frames still phase 0, 16th frame flips.
      vs_pulses(15);
      pix(8, 5, 1'b1);
      chk("blink 15 frames", int'(color), 7);
      vs_pulses(1);
      pix(8, 5, 1'b1);
      chk("blink 16 frames color", int'(color), 0);
      chk("blink 16 frames intensity", int'(intensity), 0);
      pix(0, 5, 1'b1);
      chk("no-blink cell in phase 1", int'(color), 7);
      vs_pulses(16);
      pix(8, 5, 1'b1);
      chk("blink back on", int'(color), 7);

      // Cursor on cell (5,2): underline on scanlines 14-15 in phase 0.
      cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 6'd2;
      pix(40, 46, 1'b1);
      chk("cursor line14 color", int'(color), 6);
      chk("cursor line14 intensity", int'(intensity), 1);
      pix(47, 47, 1'b1);
      chk("cursor line15", int'(color), 6);
      pix(40, 45, 1'b1);
      chk("cursor line13", int'(color), 0);
      pix(48, 46, 1'b1);
      chk("cursor next cell", int'(color), 0);
      vs_pulses(16);
      pix(40, 46, 1'b1);
      chk("cursor phase1", int'(color), 0);

      // Blank-only write port held during active video.
      wr_addr = 12'd0; wr_data = 16'h0F41; b_wr_valid = 1'b1;
      pixel_x = 10'd0; pixel_y = 10'd5; video_on = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("blank-only ready active", int'(b_wr_ready), 0);
      end
      chk("blank-only write held off", int'(b_color), 0);
      video_on = 1'b0;
      #0;
      chk("blank-only ready blank", int'(b_wr_ready), 1);
      step();
      b_wr_valid = 1'b0;
      pix(0, 5, 1'b1);
      chk("blank-only write landed", int'(b_color), 7);
      chk("blank-only write intensity", int'(b_intensity), 1);

      // Reset mid-line: black and idle syncs at once, recovery after 3 clocks.
      hsync_n_in = 1'b0;
      pix(0, 5, 1'b1);
      chk("pre-reset color", int'(color), 7);
      reset = 1'b1;
      step();
      chk("mid reset color", int'(color), 0);
      chk("mid reset hsync", int'(hsync_n_out), 1);
      reset = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("post reset color", int'(color), (i == 3) ? 7 : 0);
         chk("post reset hsync", int'(hsync_n_out), (i == 3) ? 0 : 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
